// File: rtl/pic_host_pkg.sv
// rtl/pic_host_pkg.sv - shared states and timing constants for the 8259 host bus initiator
package pic_host_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER,
    ST_INTA1,
    ST_INTA_GAP,
    ST_INTA2,
    ST_VEC_OUT,
    ST_LOCKOUT
  } state_t;

  localparam int SETUP_CYC_DEF    = 1;
  localparam int PULSE_CYC_DEF    = 2;
  localparam int RECOVERY_CYC_DEF = 1;
  localparam int LOCKOUT_CYC      = 3;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pic_host_if_int_sync.sv
// rtl/pic_host_if_int_sync.sv - two-flop synchronizer for the asynchronous PIC INT line
module pic_int_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pic_host_if.sv
// rtl/pic_host_if.sv - 8259 CPU-pin initiator: register write/read cycles and 8086-mode INTA sequence
module pic_host_if
  import pic_host_pkg::*;
#(
  parameter int SETUP_CYC    = SETUP_CYC_DEF,
  parameter int PULSE_CYC    = PULSE_CYC_DEF,
  parameter int RECOVERY_CYC = RECOVERY_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_a0,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  input  logic       int_en,
  input  logic       pic_int,
  output logic       vec_valid,
  output logic [7:0] vec,
  input  logic       vec_ready,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       inta_n,
  output logic       a0,
  output logic [7:0] dout,
  output logic       dout_oe,
  input  logic [7:0] din
);

  localparam int CW = $clog2(max4(SETUP_CYC, PULSE_CYC, RECOVERY_CYC, LOCKOUT_CYC)) + 1;
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] REC_LD   = CW'(RECOVERY_CYC - 1);
  localparam logic [CW-1:0] LOCK_LD  = CW'(LOCKOUT_CYC - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          wr_q;
  logic          int_s;
  logic          ack_pending;

  pic_int_sync u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (pic_int),
    .q   (int_s)
  );

  assign ack_pending = int_en && int_s;
  // An armed acknowledge blocks new commands so it always wins the IDLE decision.
  assign req_ready   = !rst && (state == ST_IDLE) && !ack_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      cs_n      <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      inta_n    <= 1'b1;
      a0        <= 1'b0;
      dout      <= 8'h00;
      dout_oe   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      vec_valid <= 1'b0;
      vec       <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ack_pending) begin
            state  <= ST_INTA1;
            inta_n <= 1'b0;
            cnt    <= PULSE_LD;
          end else if (req_valid) begin
            state   <= ST_SETUP;
            wr_q    <= req_write;
            a0      <= req_a0;
            cs_n    <= 1'b0;
            dout    <= req_wdata;
            dout_oe <= req_write;
            cnt     <= SETUP_LD;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            state <= ST_STROBE;
            cnt   <= PULSE_LD;
            if (wr_q) wr_n <= 1'b0;
            else      rd_n <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt == '0) begin
            state <= ST_HOLD;
            wr_n  <= 1'b1;
            rd_n  <= 1'b1;
            if (!wr_q) rsp_rdata <= din;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          state     <= ST_RECOVER;
          cs_n      <= 1'b1;
          dout_oe   <= 1'b0;
          rsp_valid <= !wr_q;
          cnt       <= REC_LD;
        end
        ST_RECOVER: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        ST_INTA1: begin
          if (cnt == '0) begin
            state  <= ST_INTA_GAP;
            inta_n <= 1'b1;
            cnt    <= REC_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_INTA_GAP: begin
          if (cnt == '0) begin
            state  <= ST_INTA2;
            inta_n <= 1'b0;
            cnt    <= PULSE_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_INTA2: begin
          if (cnt == '0) begin
            state     <= ST_VEC_OUT;
            inta_n    <= 1'b1;
            vec       <= din;
            vec_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_VEC_OUT: begin
          if (vec_ready) begin
            state     <= ST_LOCKOUT;
            vec_valid <= 1'b0;
            cnt       <= LOCK_LD;
          end
        end
        // Gives the synchronizer time to see the PIC drop INT after the acknowledge.
        ST_LOCKOUT: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_host_if.sv
// tb/tb_pic_host_if.sv - randomized directed bench for pic_host_if against a cycle-position model
module tb_pic_host_if;

  localparam int S = 1;
  localparam int P = 2;
  localparam int R = 1;
  localparam int L = 3;

  logic       clk, rst;
  logic       req_valid, req_ready, req_write, req_a0;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       int_en, pic_int;
  logic       vec_valid;
  logic [7:0] vec;
  logic       vec_ready;
  logic       cs_n, rd_n, wr_n, inta_n, a0;
  logic [7:0] dout;
  logic       dout_oe;
  logic [7:0] din;

  int vectors = 0;
  int miscompares = 0;

  pic_host_if #(
    .SETUP_CYC    (S),
    .PULSE_CYC    (P),
    .RECOVERY_CYC (R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_a0    (req_a0),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .int_en    (int_en),
    .pic_int   (pic_int),
    .vec_valid (vec_valid),
    .vec       (vec),
    .vec_ready (vec_ready),
    .cs_n      (cs_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .inta_n    (inta_n),
    .a0        (a0),
    .dout      (dout),
    .dout_oe   (dout_oe),
    .din       (din)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle; cycle k is the k-th clock after the handshake edge, sampled mid-cycle.
  task automatic do_txn(input logic w, input logic a, input logic [7:0] wd);
    int budget;
    logic [7:0] dsample;
    bit in_cs, in_strb;
    req_write = w;
    req_a0    = a;
    req_wdata = wd;
    req_valid = 1'b1;
    budget    = 0;
    dsample   = 8'h00;
    while (!req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("handshake_wait", 32'(budget < 50), 32'd1);
    if (budget >= 50) begin
      req_valid = 1'b0;
      return;
    end
    for (int k = 1; k <= S + P + R + 2; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      in_cs   = (k <= S + P + 1);
      in_strb = (k > S) && (k <= S + P);
      chk("cs_n",   32'(cs_n),   32'(!in_cs));
      chk("wr_n",   32'(wr_n),   32'(!(w && in_strb)));
      chk("rd_n",   32'(rd_n),   32'(!(!w && in_strb)));
      chk("inta_n", 32'(inta_n), 32'd1);
      chk("dout_oe", 32'(dout_oe), 32'(w && in_cs));
      if (in_cs) chk("a0", 32'(a0), 32'(a));
      if (in_cs && w) chk("dout", 32'(dout), 32'(wd));
      chk("rsp_valid", 32'(rsp_valid), 32'(!w && k == S + P + 2));
      if (!w && k == S + P + 2) chk("rsp_rdata", 32'(rsp_rdata), 32'(dsample));
      chk("req_ready", 32'(req_ready), 32'(k == S + P + R + 2));
      din = 8'($urandom);
      if (k == S + P) dsample = din;
    end
  endtask

  task automatic do_ack(input bit simul);
    logic [7:0] vexp;
    int hold;
    vexp    = 8'h00;
    int_en  = 1'b1;
    pic_int = 1'b1;
    @(negedge clk);
    chk("ack_sync1_inta", 32'(inta_n), 32'd1);
    @(negedge clk);
    chk("ack_prio_ready", 32'(req_ready), 32'd0);
    chk("ack_sync2_inta", 32'(inta_n), 32'd1);
    if (simul) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_a0    = 1'b1;
      req_wdata = 8'h5a;
    end
    for (int j = 1; j <= 2 * P + R + 1; j++) begin
      @(negedge clk);
      chk("ack_inta_n", 32'(inta_n), 32'(!(j <= P || (j > P + R && j <= 2 * P + R))));
      chk("ack_cs_n", 32'(cs_n), 32'd1);
      chk("ack_ready", 32'(req_ready), 32'd0);
      chk("ack_vec_valid", 32'(vec_valid), 32'(j == 2 * P + R + 1));
      if (j == 2 * P + R + 1) chk("ack_vec", 32'(vec), 32'(vexp));
      if (j == 1) pic_int = 1'b0;
      din = 8'($urandom);
      if (j == 2 * P + R) vexp = din;
    end
    hold = int'($urandom_range(0, 3));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("vec_hold_valid", 32'(vec_valid), 32'd1);
      chk("vec_hold", 32'(vec), 32'(vexp));
      din = 8'($urandom);
    end
    vec_ready = 1'b1;
    for (int l = 1; l <= L + 1; l++) begin
      @(negedge clk);
      vec_ready = 1'b0;
      chk("lock_vec_valid", 32'(vec_valid), 32'd0);
      chk("lock_inta_n", 32'(inta_n), 32'd1);
      chk("lock_ready", 32'(req_ready), 32'(l == L + 1));
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_a0    = 1'b0;
    req_wdata = 8'h00;
    int_en    = 1'b0;
    pic_int   = 1'b0;
    vec_ready = 1'b0;
    din       = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_rd_n", 32'(rd_n), 32'd1);
    chk("rst_wr_n", 32'(wr_n), 32'd1);
    chk("rst_inta_n", 32'(inta_n), 32'd1);
    chk("rst_a0", 32'(a0), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dout_oe", 32'(dout_oe), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_rdata}), 32'd0);
    chk("rst_vec", 32'({vec_valid, vec}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    do_txn(1'b1, 1'b0, 8'h13);
    do_txn(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_txn(1'($urandom), 1'($urandom), 8'($urandom));
    end

    do_ack(1'b0);
    do_txn(1'b0, 1'b0, 8'h00);
    do_ack(1'b1);
    do_txn(1'b1, 1'b1, 8'h5a);

    int_en  = 1'b0;
    pic_int = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("noen_inta_n", 32'(inta_n), 32'd1);
      chk("noen_ready", 32'(req_ready), 32'd1);
    end
    do_txn(1'b1, 1'b0, 8'($urandom));
    do_txn(1'b0, 1'b1, 8'h00);
    pic_int = 1'b0;
    repeat (3) @(negedge clk);

    req_write = 1'b1;
    req_a0    = 1'b1;
    req_wdata = 8'h77;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_strobe_wr_n", 32'(wr_n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_wr_n", 32'(wr_n), 32'd1);
    chk("rstmid_cs_n", 32'(cs_n), 32'd1);
    chk("rstmid_dout_oe", 32'(dout_oe), 32'd0);
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_idle_ready", 32'(req_ready), 32'd1);
    chk("rstmid_cs_idle", 32'(cs_n), 32'd1);
    chk("rstmid_no_rsp", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
